// File: rtl/bsg_upstream_out_serializer_pkg.sv
// Shared types and elaboration helpers for the parametrised upstream output serializer.
package bsg_upstream_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    function automatic int unsigned calc_beats(input int unsigned core_w,
                                               input int unsigned num_ch,
                                               input int unsigned ch_w);
        return core_w / (num_ch * ch_w);
    endfunction

    function automatic int unsigned calc_bw(input int unsigned beats);
        return (beats <= 1) ? 1 : $clog2(beats);
    endfunction

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

    // Word must split into whole beats; FIFO pointers rely on natural wrap.
    function automatic bit params_ok(input int unsigned core_w,
                                     input int unsigned num_ch,
                                     input int unsigned ch_w,
                                     input int unsigned fifo_depth);
        return (num_ch != 0) && (ch_w != 0) && (core_w != 0)
            && ((core_w % (num_ch * ch_w)) == 0)
            && is_pow2(fifo_depth) && (fifo_depth >= 2);
    endfunction

endpackage

// File: rtl/bsg_upstream_out_serializer_if.sv
// Core-side word handshake and io-side beat handshake of the upstream serializer.
interface bsg_upstream_out_serializer_if
    import bsg_upstream_pkg::*;
#(
    parameter int unsigned CORE_W = 64,
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CH_W   = 8
);
    localparam int unsigned IO_W = NUM_CH * CH_W;
    localparam int unsigned BW   = calc_bw(calc_beats(CORE_W, NUM_CH, CH_W));

    logic              core_valid_in;
    logic [CORE_W-1:0] core_data_in;
    logic              core_ready_out;
    logic              io_ready;
    logic              io_valid_out;
    logic [IO_W-1:0]   io_data_out;
    logic [BW-1:0]     io_beat_idx;
    logic              busy;

    // Serializer side.
    modport master (
        input  core_valid_in, core_data_in, io_ready,
        output core_ready_out, io_valid_out, io_data_out, io_beat_idx, busy
    );

    // Producer / io driver side.
    modport slave (
        output core_valid_in, core_data_in, io_ready,
        input  core_ready_out, io_valid_out, io_data_out, io_beat_idx, busy
    );

endinterface

// File: rtl/bsg_upstream_out_serializer_fifo.sv
// Small synchronous word FIFO; read data is the combinational head entry.
module bsg_upstream_fifo
    import bsg_upstream_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bsg_upstream_out_serializer.sv
// Buffers core words and serialises each over BEATS io beats of NUM_CH*CH_W bits.
module bsg_upstream_out_serializer
    import bsg_upstream_pkg::*;
#(
    parameter int unsigned CORE_W     = 64,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned CH_W       = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    bsg_upstream_out_serializer_if.master ifc
);
    localparam int unsigned IO_W  = NUM_CH * CH_W;
    localparam int unsigned BEATS = calc_beats(CORE_W, NUM_CH, CH_W);
    localparam int unsigned BW    = calc_bw(BEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    if (!params_ok(CORE_W, NUM_CH, CH_W, FIFO_DEPTH)) begin : g_param_check
        $error("bsg_upstream_out_serializer: CORE_W must divide into NUM_CH*CH_W beats and FIFO_DEPTH must be a power of 2 >= 2");
    end

    state_e            state;
    logic [CORE_W-1:0] shreg;
    logic [BW-1:0]     beat;
    logic              valid_q;
    logic              ready_en;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CORE_W-1:0] fifo_data;
    logic              push;
    logic              pop;
    logic              last;

    // ready_en keeps core_ready_out low through reset and releases it one edge later.
    assign ifc.core_ready_out = ready_en && !fifo_full;
    assign push               = ifc.core_valid_in && ifc.core_ready_out;
    assign last               = (beat == LAST_BEAT);
    assign pop                = !fifo_empty
                              && ((state == IDLE) || (ifc.io_ready && last));

    bsg_upstream_fifo #(
        .WIDTH (CORE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (ifc.core_data_in),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            beat     <= '0;
            valid_q  <= 1'b0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg   <= fifo_data;
                        beat    <= '0;
                        valid_q <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (ifc.io_ready) begin
                        if (!last) begin
                            shreg <= shreg >> IO_W;
                            beat  <= beat + BW'(1);
                        end else if (pop) begin
                            // Next word loads straight behind the last beat, no bubble.
                            shreg <= fifo_data;
                            beat  <= '0;
                        end else begin
                            valid_q <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign ifc.io_valid_out = valid_q;
    assign ifc.io_data_out  = shreg[IO_W-1:0];
    assign ifc.io_beat_idx  = beat;
    assign ifc.busy         = !fifo_empty || (state == SEND);

endmodule

// File: tb/tb_bsg_upstream_out_serializer.sv
// Scoreboard bench: expected beats queued at push time, popped by per-DUT monitors.
module tb_bsg_upstream_out_serializer;
    import bsg_upstream_pkg::*;

    typedef struct {
        logic [63:0] data;
        int unsigned idx;
    } beat_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    beat_t qa[$];
    beat_t qb[$];
    beat_t qc[$];

    bsg_upstream_out_serializer_if #(.CORE_W(64), .NUM_CH(2), .CH_W(8)) ia ();
    bsg_upstream_out_serializer_if #(.CORE_W(64), .NUM_CH(4), .CH_W(8)) ib ();
    bsg_upstream_out_serializer_if #(.CORE_W(64), .NUM_CH(8), .CH_W(8)) ic ();

    bsg_upstream_out_serializer #(.CORE_W(64), .NUM_CH(2), .CH_W(8), .FIFO_DEPTH(4))
        dut_a (.clk(clk), .rst(rst), .ifc(ia));
    bsg_upstream_out_serializer #(.CORE_W(64), .NUM_CH(4), .CH_W(8), .FIFO_DEPTH(4))
        dut_b (.clk(clk), .rst(rst), .ifc(ib));
    bsg_upstream_out_serializer #(.CORE_W(64), .NUM_CH(8), .CH_W(8), .FIFO_DEPTH(4))
        dut_c (.clk(clk), .rst(rst), .ifc(ic));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic int unsigned qsize(input int unsigned which);
        case (which)
            0:       return qa.size();
            1:       return qb.size();
            default: return qc.size();
        endcase
    endfunction

    function automatic logic ready_of(input int unsigned which);
        case (which)
            0:       return ia.core_ready_out;
            1:       return ib.core_ready_out;
            default: return ic.core_ready_out;
        endcase
    endfunction

    function automatic logic valid_of(input int unsigned which);
        case (which)
            0:       return ia.io_valid_out;
            1:       return ib.io_valid_out;
            default: return ic.io_valid_out;
        endcase
    endfunction

    function automatic void expect_word(input int unsigned which, input logic [63:0] w);
        int unsigned io_w;
        logic [63:0] sh;
        logic [63:0] mask;
        beat_t       e;
        io_w = (which == 0) ? 16 : (which == 1) ? 32 : 64;
        mask = (io_w == 64) ? '1 : ((64'd1 << io_w) - 64'd1);
        sh   = w;
        for (int unsigned b = 0; b < 64 / io_w; b++) begin
            e.data = sh & mask;
            e.idx  = b;
            case (which)
                0:       qa.push_back(e);
                1:       qb.push_back(e);
                default: qc.push_back(e);
            endcase
            sh = sh >> io_w;
        end
    endfunction

    task automatic mon(input int unsigned which, input logic [63:0] data, input int unsigned idx);
        beat_t e;
        if (qsize(which) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat dut%0d: got data %h idx %0d, required no beat", which, data, idx);
        end else begin
            case (which)
                0:       e = qa.pop_front();
                1:       e = qb.pop_front();
                default: e = qc.pop_front();
            endcase
            chk($sformatf("beat_data dut%0d", which), data, e.data);
            chk($sformatf("beat_idx dut%0d", which), 64'(idx), 64'(e.idx));
        end
    endtask

    always @(negedge clk)
        if (!rst && ia.io_valid_out && ia.io_ready)
            mon(0, 64'(ia.io_data_out), int'(ia.io_beat_idx));
    always @(negedge clk)
        if (!rst && ib.io_valid_out && ib.io_ready)
            mon(1, 64'(ib.io_data_out), int'(ib.io_beat_idx));
    always @(negedge clk)
        if (!rst && ic.io_valid_out && ic.io_ready)
            mon(2, 64'(ic.io_data_out), int'(ic.io_beat_idx));

    // Returns #1 after the edge on which the word was accepted.
    task automatic push(input int unsigned which, input logic [63:0] w);
        int unsigned n;
        logic        rdy;
        n = 0;
        case (which)
            0:       begin ia.core_valid_in = 1'b1; ia.core_data_in = w; end
            1:       begin ib.core_valid_in = 1'b1; ib.core_data_in = w; end
            default: begin ic.core_valid_in = 1'b1; ic.core_data_in = w; end
        endcase
        @(negedge clk);
        rdy = ready_of(which);
        while (!rdy && n < 100) begin
            @(negedge clk);
            rdy = ready_of(which);
            n++;
        end
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL push_timeout dut%0d: got core_ready_out 0, required 1 within 100 cycles", which);
        end else begin
            expect_word(which, w);
        end
        @(posedge clk);
        #1;
        ia.core_valid_in = 1'b0;
        ib.core_valid_in = 1'b0;
        ic.core_valid_in = 1'b0;
    endtask

    task automatic drain(input int unsigned which);
        int unsigned n;
        n = 0;
        while (qsize(which) != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (qsize(which) != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout dut%0d: got %0d beats outstanding, required 0", which, qsize(which));
        end else begin
            chk($sformatf("idle_valid dut%0d", which), 64'(valid_of(which)), 64'd0);
        end
    endtask

    task automatic wait_beat(input int unsigned idx);
        int unsigned n;
        n = 0;
        while (!(ia.io_valid_out && int'(ia.io_beat_idx) == idx) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("reach_beat%0d", idx), 64'(ia.io_beat_idx), 64'(idx));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before 200000");
        $fatal(1);
    end

    initial begin
        int unsigned nvalid;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        ia.core_valid_in = 1'b0; ia.core_data_in = '0; ia.io_ready = 1'b1;
        ib.core_valid_in = 1'b0; ib.core_data_in = '0; ib.io_ready = 1'b1;
        ic.core_valid_in = 1'b0; ic.core_data_in = '0; ic.io_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 64'(ia.io_valid_out), 64'd0);
        chk("reset_data", 64'(ia.io_data_out), 64'd0);
        chk("reset_idx", 64'(ia.io_beat_idx), 64'd0);
        chk("reset_busy", 64'(ia.busy), 64'd0);
        chk("reset_core_ready", 64'(ia.core_ready_out), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("core_ready_after_reset", 64'(ia.core_ready_out), 64'd1);

        // Single word, latency and beat order
        push(0, 64'h8877_6655_4433_2211);
        chk("lat_valid_e0", 64'(ia.io_valid_out), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_valid_e1", 64'(ia.io_valid_out), 64'd1);
        chk("lat_data_e1", 64'(ia.io_data_out), 64'h2211);
        chk("lat_idx_e1", 64'(ia.io_beat_idx), 64'd0);
        drain(0);
        chk("idle_busy", 64'(ia.busy), 64'd0);

        // Back-to-back words, no bubble
        push(0, 64'hAAAA_BBBB_CCCC_0011);
        push(0, 64'h1234_5678_9ABC_0022);
        nvalid = 0;
        for (int i = 0; i < 8; i++) begin
            if (ia.io_valid_out) nvalid++;
            @(posedge clk);
            #1;
        end
        chk("b2b_valid_beats", 64'(nvalid), 64'd8);
        drain(0);

        // Backpressure hold at beat 2
        push(0, 64'h8877_6655_4433_2211);
        wait_beat(2);
        ia.io_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_data", 64'(ia.io_data_out), 64'h6655);
            chk("hold_idx", 64'(ia.io_beat_idx), 64'd2);
        end
        ia.io_ready = 1'b1;
        drain(0);

        // Fill: one word in the shift register plus four buffered
        ia.io_ready = 1'b0;
        push(0, 64'h0101_0202_0303_0404);
        push(0, 64'h1111_2222_3333_4444);
        push(0, 64'h5555_6666_7777_8888);
        push(0, 64'h9999_AAAA_BBBB_CCCC);
        chk("fill_ready_after4", 64'(ia.core_ready_out), 64'd1);
        push(0, 64'hDDDD_EEEE_FFFF_0000);
        chk("fill_ready_after5", 64'(ia.core_ready_out), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("fill_ready_held", 64'(ia.core_ready_out), 64'd0);
        chk("fill_busy", 64'(ia.busy), 64'd1);
        ia.io_ready = 1'b1;
        drain(0);

        // Reset during beat 1 discards in-flight and buffered words
        push(0, 64'hDEAD_BEEF_CAFE_F00D);
        push(0, 64'h0BAD_0BAD_0BAD_0BAD);
        wait_beat(1);
        rst = 1'b1;
        qa.delete();
        @(posedge clk);
        #1;
        chk("midrst_valid", 64'(ia.io_valid_out), 64'd0);
        chk("midrst_busy", 64'(ia.busy), 64'd0);
        chk("midrst_core_ready", 64'(ia.core_ready_out), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("postrst_core_ready", 64'(ia.core_ready_out), 64'd1);
        chk("postrst_valid", 64'(ia.io_valid_out), 64'd0);
        push(0, 64'h7766_5544_3322_1100);
        drain(0);

        // NUM_CH=4: two 32-bit beats per word
        push(1, 64'h8877_6655_4433_2211);
        @(posedge clk);
        #1;
        chk("b_beat0_data", 64'(ib.io_data_out), 64'h4433_2211);
        chk("b_beat0_idx", 64'(ib.io_beat_idx), 64'd0);
        @(posedge clk);
        #1;
        chk("b_beat1_data", 64'(ib.io_data_out), 64'h8877_6655);
        chk("b_beat1_idx", 64'(ib.io_beat_idx), 64'd1);
        drain(1);

        // NUM_CH=8: whole word per beat, index pinned at 0
        push(2, 64'h8877_6655_4433_2211);
        push(2, 64'h0123_4567_89AB_CDEF);
        chk("c_word0_data", 64'(ic.io_data_out), 64'h8877_6655_4433_2211);
        chk("c_word0_idx", 64'(ic.io_beat_idx), 64'd0);
        @(posedge clk);
        #1;
        chk("c_word1_data", 64'(ic.io_data_out), 64'h0123_4567_89AB_CDEF);
        chk("c_word1_idx", 64'(ic.io_beat_idx), 64'd0);
        drain(2);

        repeat (10) @(posedge clk);
        #1;
        chk("final_qa_empty", 64'(qa.size()), 64'd0);
        chk("final_qb_empty", 64'(qb.size()), 64'd0);
        chk("final_qc_empty", 64'(qc.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
